// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the idli core.
// Contents used by the SQI controller:
//   sqi_mode_t   - pin direction of the SQI nibble bus
//   sqi_state_t  - SQI master transaction states
//   SQI_CMD_RD / SQI_CMD_WR - SQI SRAM read / write command bytes
//   SQI_CMD_NIBBLES / SQI_ADDR_NIBBLES - slot counts of the command and address phases
package idli_pkg;

  typedef enum logic {
    SQI_MODE_IN  = 1'b0,
    SQI_MODE_OUT = 1'b1
  } sqi_mode_t;

  typedef enum logic [2:0] {
    SQI_STATE_IDLE,
    SQI_STATE_CMD,
    SQI_STATE_ADDR,
    SQI_STATE_DUMMY,
    SQI_STATE_DATA,
    SQI_STATE_END
  } sqi_state_t;

  localparam logic [7:0] SQI_CMD_RD = 8'h03;
  localparam logic [7:0] SQI_CMD_WR = 8'h02;

  localparam int SQI_CMD_NIBBLES  = 2;
  localparam int SQI_ADDR_NIBBLES = 6;

endpackage

// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: nibble-wide SQI master between the idli core and an external
// SQI SRAM. A word-address request becomes CMD / ADDR / DUMMY / DATA pin
// sequencing with SCK at half the core clock; data nibbles stream until the
// core raises i_stop.
// Build option: define IDLI_SQI_WR_EN to enable the write path. Without it
// every transaction is a read and o_wr_ready stays low.
// Ports:
//   i_clk, i_rst_n          core clock, asynchronous active-low reset
//   i_req, i_wr, i_addr     transaction request (accepted when o_busy==0)
//   i_stop                  end burst after the current data nibble
//   o_busy                  transaction in progress, including the CS-high tail
//   o_rd_data, o_rd_valid   read nibble and its one-cycle strobe
//   i_wr_data, o_wr_ready   write nibble and its one-cycle request strobe
//   o_sqi_cs_n, o_sqi_sck   SQI chip select (active low) and serial clock
//   o_sqi_sio, i_sqi_sio    SQI nibble bus out / in
//   o_sqi_mode              SQI pin direction
module idli_sqi_ctrl
  import idli_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DUMMY_NIBBLES = 2,
  parameter int END_CYCLES    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_stop,
  output logic              o_busy,
  output logic [3:0]        o_rd_data,
  output logic              o_rd_valid,
  input  logic [3:0]        i_wr_data,
  output logic              o_wr_ready,
  output logic              o_sqi_cs_n,
  output logic              o_sqi_sck,
  output logic [3:0]        o_sqi_sio,
  input  logic [3:0]        i_sqi_sio,
  output sqi_mode_t         o_sqi_mode
);

  sqi_state_t  r_state;
  sqi_state_t  w_next;
  logic        r_phase;      // 0: SCK low, bus updated; 1: SCK high, memory samples
  logic [2:0]  r_nib;        // slot counter within CMD/ADDR/DUMMY, cycle counter in END
  logic [31:0] r_shift;      // command byte + 24-bit byte address, MS nibble first
  logic        r_wr;
  logic [3:0]  r_wr_nib;
  logic [3:0]  r_rd_data;
  logic        r_rd_valid;
  logic        w_wr;
  logic [23:0] w_byte_addr;

`ifdef IDLI_SQI_WR_EN
  assign w_wr = i_wr;
`else
  logic w_unused;
  assign w_wr     = 1'b0;
  assign w_unused = i_wr;
`endif

  assign w_byte_addr = 24'({i_addr, 1'b0});

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= SQI_STATE_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; slot-based states only advance at the end of phase1
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SQI_STATE_IDLE:
        if (i_req) w_next = SQI_STATE_CMD;
      SQI_STATE_CMD:
        if (r_phase && r_nib == 3'(SQI_CMD_NIBBLES - 1)) w_next = SQI_STATE_ADDR;
      SQI_STATE_ADDR:
        if (r_phase && r_nib == 3'(SQI_ADDR_NIBBLES - 1))
          w_next = (!r_wr && DUMMY_NIBBLES > 0) ? SQI_STATE_DUMMY : SQI_STATE_DATA;
      SQI_STATE_DUMMY:
        if (r_phase && r_nib == 3'(DUMMY_NIBBLES - 1)) w_next = SQI_STATE_DATA;
      SQI_STATE_DATA:
        if (r_phase && i_stop)
          w_next = (END_CYCLES > 0) ? SQI_STATE_END : SQI_STATE_IDLE;
      SQI_STATE_END:
        if (r_nib == 3'(END_CYCLES - 1)) w_next = SQI_STATE_IDLE;
      default:
        w_next = SQI_STATE_IDLE;
    endcase
  end

  // Phase, slot counter, shift register and data capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase    <= 1'b0;
      r_nib      <= '0;
      r_shift    <= '0;
      r_wr       <= 1'b0;
      r_wr_nib   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      unique case (r_state)
        SQI_STATE_IDLE: begin
          r_phase <= 1'b0;
          r_nib   <= '0;
          if (i_req) begin
            r_shift <= {(w_wr ? SQI_CMD_WR : SQI_CMD_RD), w_byte_addr};
            r_wr    <= w_wr;
          end
        end
        SQI_STATE_END: begin
          r_phase <= 1'b0;
          r_nib   <= r_nib + 3'd1;
        end
        default: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_shift <= {r_shift[27:0], 4'h0};
            r_nib   <= (w_next != r_state) ? '0 : r_nib + 3'd1;
          end
          if (r_state == SQI_STATE_DATA) begin
            if (!r_phase && r_wr) r_wr_nib <= i_wr_data;
            if (r_phase && !r_wr) begin
              r_rd_data  <= i_sqi_sio;
              r_rd_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Outputs. During write DATA phase0 the incoming nibble goes straight to
  // the pins; phase1 replays the captured copy so the memory sees it stable.
  always_comb begin
    o_busy     = (r_state != SQI_STATE_IDLE);
    o_sqi_cs_n = 1'b1;
    o_sqi_sck  = 1'b0;
    o_sqi_sio  = 4'h0;
    o_sqi_mode = SQI_MODE_IN;
    o_wr_ready = 1'b0;
    o_rd_data  = r_rd_data;
    o_rd_valid = r_rd_valid;
    unique case (r_state)
      SQI_STATE_CMD, SQI_STATE_ADDR: begin
        o_sqi_cs_n = 1'b0;
        o_sqi_sck  = r_phase;
        o_sqi_sio  = r_shift[31:28];
        o_sqi_mode = SQI_MODE_OUT;
      end
      SQI_STATE_DUMMY: begin
        o_sqi_cs_n = 1'b0;
        o_sqi_sck  = r_phase;
      end
      SQI_STATE_DATA: begin
        o_sqi_cs_n = 1'b0;
        o_sqi_sck  = r_phase;
        if (r_wr) begin
          o_sqi_mode = SQI_MODE_OUT;
          o_wr_ready = ~r_phase;
          o_sqi_sio  = r_phase ? r_wr_nib : i_wr_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// tb_idli_sqi_ctrl: directed bench for idli_sqi_ctrl with a small SQI SRAM
// model that records every nibble it samples on SCK rise and returns read
// data on SCK low. Build with IDLI_SQI_WR_EN to cover the write path.
module tb_idli_sqi_ctrl;
  import idli_pkg::*;

`ifdef IDLI_SQI_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        clk;
  logic        i_rst_n;
  logic        i_req;
  logic        i_wr;
  logic [15:0] i_addr;
  logic        i_stop;
  logic        o_busy;
  logic [3:0]  o_rd_data;
  logic        o_rd_valid;
  logic [3:0]  i_wr_data;
  logic        o_wr_ready;
  logic        o_sqi_cs_n;
  logic        o_sqi_sck;
  logic [3:0]  o_sqi_sio;
  logic [3:0]  i_sqi_sio;
  sqi_mode_t   o_sqi_mode;

  idli_sqi_ctrl #(.ADDR_W(16), .DUMMY_NIBBLES(2), .END_CYCLES(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req),
    .i_wr       (i_wr),
    .i_addr     (i_addr),
    .i_stop     (i_stop),
    .o_busy     (o_busy),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .o_sqi_cs_n (o_sqi_cs_n),
    .o_sqi_sck  (o_sqi_sck),
    .o_sqi_sio  (o_sqi_sio),
    .i_sqi_sio  (i_sqi_sio),
    .o_sqi_mode (o_sqi_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model and observation logs (single writer: this block)
  logic [15:0] mem_data = 16'h0;
  logic [3:0]  cap_sio [32];
  sqi_mode_t   cap_mode[32];
  int slots = 0, nrd = 0, nwr = 0, nend = 0, nacc = 0, t_acc = 0;
  int first_rd = -1, last_rd = -1, wr_c0 = -1, wr_c1 = -1, acc_prev = 0;
  logic [15:0] rd_pack = 16'h0;
  logic        prev_sck = 1'b0;

  always @(negedge clk) begin
    if (!i_rst_n) begin
      slots = 0;
    end else if (i_req && !o_busy) begin
      nacc++;
      acc_prev = t_acc;
      t_acc    = cyc;
      slots = 0; nrd = 0; nwr = 0; nend = 0; rd_pack = 16'h0;
      first_rd = -1; last_rd = -1; wr_c0 = -1; wr_c1 = -1;
    end else begin
      if (!o_sqi_cs_n && o_sqi_sck && !prev_sck && slots < 32) begin
        cap_sio[slots]  = o_sqi_sio;
        cap_mode[slots] = o_sqi_mode;
        slots++;
      end
      if (o_rd_valid) begin
        if (nrd == 0) first_rd = cyc - t_acc;
        last_rd = cyc - t_acc;
        if (nrd < 4) rd_pack[15-4*nrd -: 4] = o_rd_data;
        nrd++;
      end
      if (o_wr_ready) begin
        if (nwr == 0) wr_c0 = cyc - t_acc;
        if (nwr == 1) wr_c1 = cyc - t_acc;
        nwr++;
      end
      if (o_busy && o_sqi_cs_n) nend++;
    end
    prev_sck = o_sqi_sck;
    if (o_sqi_cs_n) i_sqi_sio = 4'h0;
    else if (!o_sqi_sck && slots >= 10 && slots < 14) i_sqi_sio = mem_data[15-4*(slots-10) -: 4];
  end

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    int          nstop;   // data nibble on which i_stop is seen
    logic        early;   // i_stop held high from the request cycle
    logic [31:0] exp_hdr; // cmd byte + 24-bit byte address
    logic [15:0] data;    // memory read nibbles / write nibbles, first at [15:12]
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input string tag);
    logic        eff_wr;
    logic [15:0] d;
    logic [31:0] hdr;
    logic [7:0]  hmode;
    int          n, stop_c;
    bit          done;
    eff_wr = v.wr & WR_EN;
    d      = v.data;
    n      = v.early ? 1 : v.nstop;
    stop_c = v.early ? 0 : ((eff_wr ? 17 : 21) + 2*(n-1));
    mem_data = d;
    @(posedge clk); #1;
    i_req = 1'b1; i_wr = v.wr; i_addr = v.addr; i_stop = v.early;
    done = 0;
    for (int c = 1; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      i_req = 1'b0;
      if (c >= stop_c) i_stop = 1'b1;
      if (nwr < 4) i_wr_data = d[15-4*nwr -: 4];
      if (!o_busy) done = 1;
    end
    i_stop = 1'b0;
    chk({tag, " finished"}, 32'(done), 32'd1);
    for (int k = 0; k < 8; k++) begin
      hdr   = {hdr[27:0], cap_sio[k]};
      hmode = {hmode[6:0], cap_mode[k] == SQI_MODE_OUT};
    end
    chk({tag, " header nibbles"}, hdr, v.exp_hdr);
    chk({tag, " header mode"}, 32'(hmode), 32'hFF);
    chk({tag, " end cycles"}, 32'(nend), 32'd2);
    if (!eff_wr) begin
      chk({tag, " slots"}, 32'(slots), 32'(10 + n));
      chk({tag, " first rd_valid"}, 32'(first_rd), 32'd23);
      chk({tag, " last rd_valid"}, 32'(last_rd), 32'(23 + 2*(n-1)));
      chk({tag, " rd count"}, 32'(nrd), 32'(n));
      chk({tag, " rd data"}, 32'(rd_pack), 32'(d));
      chk({tag, " wr_ready count"}, 32'(nwr), 32'd0);
      chk({tag, " dummy mode"}, 32'(cap_mode[8]), 32'(SQI_MODE_IN));
      chk({tag, " data mode"}, 32'(cap_mode[10]), 32'(SQI_MODE_IN));
    end else begin
      chk({tag, " slots"}, 32'(slots), 32'(8 + n));
      chk({tag, " first wr_ready"}, 32'(wr_c0), 32'd17);
      chk({tag, " second wr_ready"}, 32'(wr_c1), (n > 1) ? 32'd19 : 32'hFFFF_FFFF);
      chk({tag, " wr count"}, 32'(nwr), 32'(n));
      chk({tag, " wr nibbles"}, 32'({cap_sio[8], cap_sio[9]}), 32'(d[15:8]));
      chk({tag, " rd count"}, 32'(nrd), 32'd0);
      chk({tag, " data mode"}, 32'(cap_mode[8+n-1]), 32'(SQI_MODE_OUT));
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 3, 1'b0, 32'h0300_2468, 16'hABC0};
    vecs[1] = '{16'hFFFF, 1'b0, 1, 1'b0, 32'h0301_FFFE, 16'h7000};
    vecs[2] = '{16'h8001, 1'b0, 4, 1'b0, 32'h0301_0002, 16'h1E2D};
`ifdef IDLI_SQI_WR_EN
    vecs[3] = '{16'h0001, 1'b1, 2, 1'b0, 32'h0200_0002, 16'h5F00};
`else
    vecs[3] = '{16'h0001, 1'b1, 2, 1'b0, 32'h0300_0002, 16'h5F00};
`endif
    vecs[4] = '{16'h00A5, 1'b0, 1, 1'b1, 32'h0300_014A, 16'h3000};

    i_rst_n = 1'b0; i_req = 1'b0; i_wr = 1'b0; i_addr = 16'h0;
    i_stop = 1'b0; i_wr_data = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cs_n", 32'(o_sqi_cs_n), 32'd1);
    chk("reset sck", 32'(o_sqi_sck), 32'd0);
    chk("reset sio", 32'(o_sqi_sio), 32'd0);
    chk("reset mode", 32'(o_sqi_mode), 32'(SQI_MODE_IN));
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset rd_valid", 32'(o_rd_valid), 32'd0);
    chk("reset wr_ready", 32'(o_wr_ready), 32'd0);
    chk("reset rd_data", 32'(o_rd_data), 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Requests while busy (ADDR and END) are dropped; a request held into the
    // first IDLE cycle is taken, and its early i_stop gives a one-nibble burst.
    begin
      int  a0, c;
      bit  done;
      logic [31:0] hdr;
      mem_data = 16'h6000;
      a0 = nacc;
      @(posedge clk); #1;
      i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h1234;
      done = 0;
      for (c = 1; c < 300 && !done; c++) begin
        @(posedge clk); #1;
        i_req = 1'b0;
        if (c == 8)  begin i_req = 1'b1; i_addr = 16'h5555; end
        if (c == 21) i_stop = 1'b1;
        if (c >= 23 && nacc == a0 + 1) begin i_req = 1'b1; i_addr = 16'h0042; end
        if (nacc == a0 + 2 && !o_busy) done = 1;
      end
      i_stop = 1'b0;
      chk("busy-req finished", 32'(done), 32'd1);
      chk("busy-req accept count", 32'(nacc - a0), 32'd2);
      chk("busy-req accept spacing", 32'(t_acc - acc_prev), 32'd25);
      for (int k = 0; k < 8; k++) hdr = {hdr[27:0], cap_sio[k]};
      chk("busy-req second header", hdr, 32'h0300_0084);
      chk("busy-req second rd count", 32'(nrd), 32'd1);
    end

    // Asynchronous reset in the 4th data nibble, then a clean read
    mem_data = 16'hABCD;
    @(posedge clk); #1;
    i_req = 1'b1; i_wr = 1'b0; i_addr = 16'h1234;
    for (int c = 1; c <= 27; c++) begin
      @(posedge clk); #1;
      i_req = 1'b0;
    end
    chk("pre-reset rd count", 32'(nrd), 32'd2);
    chk("pre-reset cs_n", 32'(o_sqi_cs_n), 32'd0);
    i_rst_n = 1'b0;
    #1;
    chk("async reset cs_n", 32'(o_sqi_cs_n), 32'd1);
    chk("async reset mode", 32'(o_sqi_mode), 32'(SQI_MODE_IN));
    chk("async reset busy", 32'(o_busy), 32'd0);
    chk("async reset sck", 32'(o_sqi_sck), 32'd0);
    chk("async reset rd_valid", 32'(o_rd_valid), 32'd0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    run_vec(vecs[0], "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
